// File: rtl/freq_div_pkg.sv
// Shared defaults, reset constants and divisor/high-time helpers for the
// multi-channel frequency divider.
// Build option: FREQ_DIV_DUTY_EN selects a programmable high time; without it
// every channel runs at 50% duty.
package freq_div_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_WIDTH  = 32;

    // Active divisor and high time after reset: divide-by-one, output high.
    localparam int RST_DIV  = 1;
    localparam int RST_HIGH = 1;

    // A divisor of zero would never wrap, so it is treated as one.
    function automatic logic [63:0] norm_div(input logic [63:0] d);
        return (d == 64'd0) ? 64'd1 : d;
    endfunction

    // A high time longer than the period simply means "always high".
    function automatic logic [63:0] clamp_high(input logic [63:0] h, input logic [63:0] n);
        return (h > n) ? n : h;
    endfunction

    // Half period rounded up, written without an n+1 that could overflow.
    function automatic logic [63:0] half_high(input logic [63:0] n);
        return (n >> 1) + {63'd0, n[0]};
    endfunction

endpackage

// File: rtl/freq_div_chan.sv
// One divider channel: period counter, shadow and active divisor/high time,
// pending-commit flag, and the registered tick and div_out outputs.
// Build option: FREQ_DIV_DUTY_EN keeps a shadow high-time register and clamps
// it at commit; otherwise the high time is derived from the divisor.
module freq_div_chan
    import freq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync,
    input  logic             accept,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             pending,
    output logic             tick,
    output logic             div_out
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_n;
    logic [WIDTH-1:0] act_h;
    logic [WIDTH-1:0] sh_n;
    logic [WIDTH-1:0] commit_h;
    logic             wrap;
    logic             commit;

`ifdef FREQ_DIV_DUTY_EN
    logic [WIDTH-1:0] sh_h;
`else
    logic unused_cfg_high;
    assign unused_cfg_high = ^cfg_high;
`endif

    // Counter only ever runs 0..act_n-1, so this compare is the period end.
    assign wrap = (cnt == act_n - WIDTH'(1));

    // A pending config lands at a period boundary: the wrap of a running
    // channel, any cycle of a stopped channel, or a realign pulse.
    assign commit = pending & (sync | ~enable | wrap);

    // High time that becomes active when the shadow divisor is committed.
    always_comb begin
`ifdef FREQ_DIV_DUTY_EN
        commit_h = WIDTH'(clamp_high(64'(sh_h), 64'(sh_n)));
`else
        commit_h = WIDTH'(half_high(64'(sh_n)));
`endif
    end

    // Configuration path: load shadow on accept, move it to active on commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            sh_n    <= '0;
`ifdef FREQ_DIV_DUTY_EN
            sh_h    <= '0;
`endif
            act_n   <= WIDTH'(RST_DIV);
            act_h   <= WIDTH'(RST_HIGH);
        end else if (accept) begin
            pending <= 1'b1;
            sh_n    <= WIDTH'(norm_div(64'(cfg_div)));
`ifdef FREQ_DIV_DUTY_EN
            sh_h    <= cfg_high;
`endif
        end else if (commit) begin
            pending <= 1'b0;
            act_n   <= sh_n;
            act_h   <= commit_h;
        end
    end

    // Period counter and outputs; the realign pulse overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            tick    <= 1'b0;
            div_out <= 1'b0;
        end else if (sync) begin
            cnt     <= '0;
            tick    <= 1'b0;
            div_out <= 1'b0;
        end else if (enable) begin
            div_out <= (cnt < act_h);
            if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + WIDTH'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
            if (commit) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/freq_div_multi.sv
// Multi-channel frequency divider: NUM_CH independent channels sharing one
// clock, a realign pulse and a valid/ready configuration port.
// Config handshake: a request on cfg_ch is taken in any cycle where
// cfg_valid and cfg_ready are both high; cfg_ready is low only while the
// addressed channel still holds an uncommitted config, and is always high for
// a channel index that does not exist (such a request is discarded).
// Build option: FREQ_DIV_DUTY_EN enables the programmable high time cfg_high.
module freq_div_multi
    import freq_div_pkg::*;
#(
    parameter int  NUM_CH = DEF_NUM_CH,
    parameter int  WIDTH  = DEF_WIDTH,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic [WIDTH-1:0]  cfg_high,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_out
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] accept;

    // Channel decode: ready reflects the addressed channel's pending flag.
    always_comb begin
        cfg_ready = 1'b1;
        accept    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_ch == CH_W'(c)) begin
                cfg_ready = ~pending[c];
                accept[c] = cfg_valid & ~pending[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        freq_div_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (enable[c]),
            .sync    (sync),
            .accept  (accept[c]),
            .cfg_div (cfg_div),
            .cfg_high(cfg_high),
            .pending (pending[c]),
            .tick    (tick[c]),
            .div_out (div_out[c])
        );
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Bench for freq_div_multi: a directed vector table for channel 0, hand
// sequences for handshake, realign, clamp and reset corners, then random
// traffic checked against a period-level model of every channel.
module tb_freq_div_multi;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] enable;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [WIDTH-1:0]  cfg_div;
    logic [WIDTH-1:0]  cfg_high;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] div_out;

    always #5 clk = ~clk;

    freq_div_multi #(
        .NUM_CH(NUM_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .tick     (tick),
        .div_out  (div_out)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    logic last_ready;

    // Reference model: each channel is a period length, a high time and a
    // position within the current period, plus an optional queued config.
    longint m_per [NUM_CH];
    longint m_hi  [NUM_CH];
    longint m_pos [NUM_CH];
    longint m_pn  [NUM_CH];
`ifdef FREQ_DIV_DUTY_EN
    longint m_ph  [NUM_CH];
`endif
    bit     m_pend[NUM_CH];
    bit     m_tick[NUM_CH];
    bit     m_div [NUM_CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_per[c]  = 1;
            m_hi[c]   = 1;
            m_pos[c]  = 0;
            m_pn[c]   = 0;
`ifdef FREQ_DIV_DUTY_EN
            m_ph[c]   = 0;
`endif
            m_pend[c] = 0;
            m_tick[c] = 0;
            m_div[c]  = 0;
        end
    endtask

    task automatic model_commit(input int c);
        m_per[c] = m_pn[c];
`ifdef FREQ_DIV_DUTY_EN
        m_hi[c] = (m_ph[c] > m_pn[c]) ? m_pn[c] : m_ph[c];
`else
        m_hi[c] = (m_pn[c] + 1) / 2;
`endif
        m_pend[c] = 0;
    endtask

    // One rising edge, using the stimulus the bench is currently driving.
    task automatic model_edge();
        bit acc;
        acc = cfg_valid && (int'(cfg_ch) < NUM_CH) && !m_pend[cfg_ch];
        for (int c = 0; c < NUM_CH; c++) begin
            if (sync) begin
                if (m_pend[c]) model_commit(c);
                m_pos[c]  = 0;
                m_tick[c] = 0;
                m_div[c]  = 0;
            end else if (enable[c]) begin
                m_div[c] = (m_pos[c] < m_hi[c]);
                if (m_pos[c] == m_per[c] - 1) begin
                    m_tick[c] = 1;
                    m_pos[c]  = 0;
                    if (m_pend[c]) model_commit(c);
                end else begin
                    m_tick[c] = 0;
                    m_pos[c]  = m_pos[c] + 1;
                end
            end else begin
                m_tick[c] = 0;
                if (m_pend[c]) begin
                    model_commit(c);
                    m_pos[c] = 0;
                end
            end
        end
        if (acc) begin
            m_pend[cfg_ch] = 1;
            m_pn[cfg_ch]   = (cfg_div == 0) ? 1 : longint'(cfg_div);
`ifdef FREQ_DIV_DUTY_EN
            m_ph[cfg_ch]   = longint'(cfg_high);
`endif
        end
    endtask

    function automatic logic [NUM_CH-1:0] tick_vec();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_tick[c];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] div_vec();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_div[c];
        return v;
    endfunction

    // Drive one cycle of stimulus, check ready before the edge and the
    // registered outputs after it.
    task automatic step(input logic [NUM_CH-1:0] en, input logic sy, input logic vl,
                        input logic [1:0] ch, input logic [WIDTH-1:0] dv,
                        input logic [WIDTH-1:0] hg);
        enable    = en;
        sync      = sy;
        cfg_valid = vl;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_high  = hg;
        @(negedge clk);
        last_ready = cfg_ready;
        chk("cfg_ready", 64'(cfg_ready), 64'(!m_pend[ch]));
        @(posedge clk);
        #1;
        model_edge();
        chk("tick", 64'(tick), 64'(tick_vec()));
        chk("div_out", 64'(div_out), 64'(div_vec()));
    endtask

    task automatic idle(input logic [NUM_CH-1:0] en, input logic [1:0] ch);
        step(en, 1'b0, 1'b0, ch, '0, '0);
    endtask

    typedef struct {
        logic [NUM_CH-1:0] en;
        logic              vl;
        logic [WIDTH-1:0]  dv;
        logic [WIDTH-1:0]  hg;
        logic [NUM_CH-1:0] x_tick;
        logic [NUM_CH-1:0] x_div;
        logic              x_ready;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int cnt;
        int first2;
        int first3;
        logic [NUM_CH-1:0] ren;

        // Channel 0: default divide-by-one, then N=5 H=3 loaded while stopped.
        tbl[0]  = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0001, 4'b0001, 1'b1};
        tbl[1]  = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0001, 4'b0001, 1'b1};
        tbl[2]  = '{4'b0000, 1'b1, 32'd5, 32'd3, 4'b0000, 4'b0001, 1'b1};
        tbl[3]  = '{4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b0001, 1'b0};
        tbl[4]  = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b0001, 1'b1};
        tbl[5]  = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b0001, 1'b1};
        tbl[6]  = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b0001, 1'b1};
        tbl[7]  = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b0000, 1'b1};
        tbl[8]  = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0001, 4'b0000, 1'b1};
        tbl[9]  = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b0001, 1'b1};
        tbl[10] = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b0001, 1'b1};
        tbl[11] = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b0001, 1'b1};
        tbl[12] = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0000, 4'b0000, 1'b1};
        tbl[13] = '{4'b0001, 1'b0, 32'd0, 32'd0, 4'b0001, 4'b0000, 1'b1};

        // Clock/reset.
        reset_n   = 1'b0;
        enable    = '0;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = '0;
        cfg_high  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_tick", 64'(tick), 64'd0);
        chk("reset_div_out", 64'(div_out), 64'd0);
        chk("reset_ready", 64'(cfg_ready), 64'd1);

        // Directed table on channel 0.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].en, 1'b0, tbl[i].vl, 2'd0, tbl[i].dv, tbl[i].hg);
            chk($sformatf("tbl%0d_ready", i), 64'(last_ready), 64'(tbl[i].x_ready));
            chk($sformatf("tbl%0d_tick", i), 64'(tick), 64'(tbl[i].x_tick));
            chk($sformatf("tbl%0d_div_out", i), 64'(div_out), 64'(tbl[i].x_div));
        end

        // Channel 1 at N=4, reconfigured to N=6 mid-period.
        step(4'b0001, 1'b0, 1'b1, 2'd1, 32'd4, 32'd2);
        idle(4'b0001, 2'd1);
        idle(4'b0011, 2'd1);
        idle(4'b0011, 2'd1);
        step(4'b0011, 1'b0, 1'b1, 2'd1, 32'd6, 32'd3);
        idle(4'b0011, 2'd1);
        chk("ch1_ready_while_pending", 64'(last_ready), 64'd0);
        chk("ch1_old_period_tick", 64'(tick[1]), 64'd1);
        cnt = 0;
        do begin
            idle(4'b0011, 2'd1);
            cnt++;
        end while (!tick[1] && cnt < 20);
        chk("ch1_new_period_len", 64'(cnt), 64'd6);

        // Channels 2 and 3 at N=3 and N=7, realigned by a sync pulse.
        step(4'b0011, 1'b0, 1'b1, 2'd2, 32'd3, 32'd1);
        step(4'b0011, 1'b0, 1'b1, 2'd3, 32'd7, 32'd3);
        idle(4'b0011, 2'd3);
        repeat (5) idle(4'b1111, 2'd0);
        step(4'b1111, 1'b1, 1'b0, 2'd0, '0, '0);
        chk("sync_tick", 64'(tick), 64'd0);
        chk("sync_div_out", 64'(div_out), 64'd0);
        first2 = 0;
        first3 = 0;
        for (int k = 1; k <= 8; k++) begin
            idle(4'b1111, 2'd0);
            if (tick[2] && first2 == 0) first2 = k;
            if (tick[3] && first3 == 0) first3 = k;
        end
        chk("ch2_first_tick_after_sync", 64'(first2), 64'd3);
        chk("ch3_first_tick_after_sync", 64'(first3), 64'd7);

        // Divisor 0 on channel 2 and oversized high time on channel 3.
        step(4'b1111, 1'b0, 1'b1, 2'd2, 32'd0, 32'd5);
        step(4'b1111, 1'b0, 1'b1, 2'd3, 32'd3, 32'd9);
        repeat (10) idle(4'b1111, 2'd0);
        for (int k = 0; k < 3; k++) begin
            idle(4'b1111, 2'd0);
            chk("ch2_div0_every_cycle", 64'(tick[2]), 64'd1);
        end

        // Reset mid-period with a queued config on channel 1.
        step(4'b1111, 1'b0, 1'b1, 2'd1, 32'd2, 32'd1);
        #2;
        reset_n   = 1'b0;
        enable    = '0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd1;
        #1;
        chk("midreset_tick", 64'(tick), 64'd0);
        chk("midreset_div_out", 64'(div_out), 64'd0);
        chk("midreset_ready", 64'(cfg_ready), 64'd1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            idle(4'b0010, 2'd1);
            chk("ch1_default_after_reset", 64'(tick[1]), 64'd1);
        end

        // Random traffic against the model.
        ren = 4'b1111;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) ren = 4'($urandom_range(0, 15));
            step(ren, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)), $urandom_range(0, 9), $urandom_range(0, 12));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/freq_div_multi.md
Name: freq_div_multi

Overview:
- Parametrised multi-channel frequency divider; successor to the single-channel divider.
- NUM_CH independent channels share one clock and a config port.
- Each channel produces a registered one-cycle TICK (clock-enable) every N enabled cycles and a registered, glitch-free DIV_OUT square wave with programmable high time.
- Reconfiguration uses a valid/ready handshake and takes effect only at a period boundary; consumers are the timer/UART/PWM enables downstream.

Parameters:
- NUM_CH, 4, number of divider channels (1..16)
- WIDTH, 32, divisor/counter width in bits
- CH_W, $clog2(NUM_CH) (min 1), channel index width (derived, not overridden)

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESET_N  input  1  asynchronous active-low reset
- ENABLE  input  NUM_CH  per-channel run enable
- SYNC  input  1  single-cycle pulse; realigns all channels
- CFG_VALID  input  1  config request
- CFG_READY  output  1  config accepted this cycle when VALID&READY
- CFG_CH  input  CH_W  target channel
- CFG_DIV  input  WIDTH  divisor N
- CFG_HIGH  input  WIDTH  high-time H in cycles (used only with duty feature)
- TICK  output  NUM_CH  one-cycle pulse per period
- DIV_OUT  output  NUM_CH  divided square wave

Behaviour:
- Reset (async assert, sync release): counter=0, active N=1, active H=1, pending=0, shadow regs=0, TICK=0, DIV_OUT=0.
- CFG_READY = !pending[CFG_CH] (combinational from registers). On VALID&READY: shadow N/H of CFG_CH loaded, pending set. CFG_CH >= NUM_CH: READY=1, request dropped.
- Divisor 0 stored as 1. H clamped to N at commit; H=0 gives DIV_OUT constant 0.
- Commit (shadow->active, pending cleared, counter<=0): at wrap while enabled, or the cycle after accept if channel disabled, or on SYNC.
- Per cycle, ENABLE[c]=1:
  - counter == N-1: counter<=0, TICK<=1.
  - else: counter++, TICK<=0.
  - DIV_OUT <= (counter < H), using the pre-update counter.
  - First TICK asserts N cycles after ENABLE rises from counter 0.
- ENABLE[c]=0: counter and DIV_OUT hold, TICK<=0.
- N=1: TICK high every enabled cycle; DIV_OUT high whenever H>=1.
- SYNC priority over wrap/increment: all counters<=0, TICK<=0, DIV_OUT<=0, pending commits applied. SYNC concurrent with an accept: accept stored as pending, committed at the next boundary.
- Arithmetic is unsigned WIDTH-bit; counter never exceeds N-1, so no wrap-around. Max period 2^WIDTH-1.
- Reset mid-period: all state to reset values immediately; pending config lost.

Optional Feature:
- Macro FREQ_DIV_DUTY_EN.
- Defined: CFG_HIGH honoured as above.
- Undefined: CFG_HIGH ignored; H = (N+1)>>1 computed at commit (50% duty, odd N high one extra cycle); H register and clamp logic removed.

Decomposition:
- Package freq_div_pkg: WIDTH default, NUM_CH default, N/H clamp helper function, reset constants.
- Sub-module freq_div_chan: one channel (counter, shadow/active regs, pending flag, TICK/DIV_OUT regs).
- Top instantiates NUM_CH copies via generate and decodes CFG_CH and READY.

Test Plan:
- Reset then ENABLE=4'b0001, defaults -> TICK[0] high every cycle, DIV_OUT[0]=1 from the second cycle; other channels TICK=0.
- Ch0 disabled, cfg N=5 H=2 -> commit next cycle; after ENABLE, TICK[0] every 5th cycle; DIV_OUT[0] pattern 1,1,0,0,0 repeating, one cycle late.
- Ch1 running N=4; cfg N=6 mid-period -> READY for ch1 low until wrap; period 4 completes, then period 6 with no short or glitched pulse.
- Ch2 and ch3 at N=3 and N=7, SYNC pulse -> both counters 0; first TICKs 3 and 7 cycles later, phase-aligned.
- Cfg N=0 and H=9 with N=3 -> stored N=1 and H=3; without FREQ_DIV_DUTY_EN, N=5 gives DIV_OUT 1,1,1,0,0.
- RESET_N asserted mid-period with a pending cfg -> outputs 0 immediately; pending dropped; active N back to 1.
